// File: rtl/mc_controller_pkg.sv
// ------------------------------------------------------------------
// Module : mc_controller_pkg
// Brief  : Shared instruction-class codes, FSM states and wb_sel codes
// Rev    : 1.0
// ------------------------------------------------------------------
`default_nettype none

package mc_controller_pkg;

    localparam logic [4:0] I_NULL = 5'd0;
    localparam logic [4:0] I_ADD  = 5'd1;
    localparam logic [4:0] I_ADDW = 5'd2;
    localparam logic [4:0] I_ADDI = 5'd3;
    localparam logic [4:0] I_LW   = 5'd4;
    localparam logic [4:0] I_SW   = 5'd5;
    localparam logic [4:0] I_JAL  = 5'd6;
    localparam logic [4:0] I_BEQ  = 5'd7;
    localparam logic [4:0] I_BNE  = 5'd8;
    localparam logic [4:0] I_BLT  = 5'd9;
    localparam logic [4:0] I_ERR  = 5'd31;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [1:0] c_wb_alu = 2'b00;
    localparam logic [1:0] c_wb_mem = 2'b01;
    localparam logic [1:0] c_wb_pc4 = 2'b10;

    // Codes that the EXEC state knows how to sequence.
    function automatic logic is_exec_op(input logic [4:0] op);
        case (op)
            I_ADD, I_ADDW, I_ADDI, I_LW, I_SW,
            I_JAL, I_BEQ, I_BNE, I_BLT: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_controller_if.sv
// ------------------------------------------------------------------
// Module : mc_controller_if
// Brief  : Controller <-> datapath/memory signal bundle
// Rev    : 1.0
// ------------------------------------------------------------------
`default_nettype none

interface mc_controller_if;

    logic [4:0]  op_type;
    logic        cmp_eq;
    logic        cmp_lt;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        rf_we;
    logic        pc_we;
    logic        pc_sel;
    logic        alu_src_b;
    logic [1:0]  wb_sel;
    logic        halted;
    logic        error;
    logic [2:0]  state;
    logic [31:0] instret;

    modport master (
        input  op_type, cmp_eq, cmp_lt, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_we, rf_we, pc_we,
               pc_sel, alu_src_b, wb_sel, halted, error, state, instret
    );

    modport slave (
        output op_type, cmp_eq, cmp_lt, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_we, rf_we, pc_we,
               pc_sel, alu_src_b, wb_sel, halted, error, state, instret
    );

endinterface

`default_nettype wire

// File: rtl/mc_controller_mem_wdt.sv
// ------------------------------------------------------------------
// Module : mem_wdt
// Brief  : Memory wait counter; flags when MEM_TIMEOUT stall cycles pass
// Rev    : 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_wdt #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int            c_w     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_w-1:0] c_limit = c_w'(MEM_TIMEOUT);

    logic [c_w-1:0] r_count;

    // Saturates at the limit so expiry cannot wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && !expired) begin
            r_count <= r_count + c_w'(1);
        end
    end

    assign expired = (r_count >= c_limit);

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ------------------------------------------------------------------
// Module : mc_controller
// Brief  : Multi-cycle CPU control FSM with memory wait watchdog
// Rev    : 1.0
// ------------------------------------------------------------------
`default_nettype none

module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    mc_controller_if.master bus
);

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_op;
    logic [31:0] r_instret;

    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_mem_addr_sel;
    logic        w_ir_we;
    logic        w_rf_we;
    logic        w_pc_we;
    logic        w_pc_sel;
    logic        w_alu_src_b;
    logic [1:0]  w_wb_sel;
    logic        w_halted;
    logic        w_error;
    logic        w_transfer;
    logic        w_wdt_clr;
    logic        w_wdt_inc;
    logic        w_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_op      <= I_NULL;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= bus.op_type;
            end
            if (w_pc_we) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_we        = 1'b0;
        w_rf_we        = 1'b0;
        w_pc_we        = 1'b0;
        w_pc_sel       = 1'b0;
        w_alu_src_b    = 1'b0;
        w_wb_sel       = c_wb_alu;
        w_halted       = 1'b0;
        w_error        = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_expired) begin
                    w_next = S_ERROR;
                end
            end
            S_DECODE: begin
                if (bus.op_type == I_NULL) begin
                    w_next = S_HALT;
                end else if (!is_exec_op(bus.op_type)) begin
                    w_next = S_ERROR;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_op)
                    I_ADD, I_ADDW: w_next = S_WB;
                    I_ADDI: begin
                        w_alu_src_b = 1'b1;
                        w_next      = S_WB;
                    end
                    I_LW, I_SW: begin
                        w_alu_src_b = 1'b1;
                        w_next      = S_MEM;
                    end
                    I_JAL: w_next = S_WB;
                    I_BEQ, I_BNE, I_BLT: begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = (r_op == I_BEQ) ?  bus.cmp_eq :
                                   (r_op == I_BNE) ? !bus.cmp_eq : bus.cmp_lt;
                        w_next   = S_FETCH;
                    end
                    default: w_next = S_ERROR;
                endcase
            end
            S_MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = (r_op == I_SW);
                if (bus.mem_ready) begin
                    if (r_op == I_SW) begin
                        w_pc_we = 1'b1;
                        w_next  = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_expired) begin
                    w_next = S_ERROR;
                end
            end
            S_WB: begin
                w_rf_we  = 1'b1;
                w_pc_we  = 1'b1;
                w_pc_sel = (r_op == I_JAL);
                w_wb_sel = (r_op == I_LW)  ? c_wb_mem :
                           (r_op == I_JAL) ? c_wb_pc4 : c_wb_alu;
                w_next   = S_FETCH;
            end
            S_HALT:  w_halted = 1'b1;
            S_ERROR: w_error  = 1'b1;
            default: w_next   = S_ERROR;
        endcase
    end

    assign w_transfer = w_mem_req & bus.mem_ready;
    assign w_wdt_inc  = w_mem_req & ~bus.mem_ready;
    assign w_wdt_clr  = w_transfer |
                        ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM)));

    mem_wdt #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wdt (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_wdt_clr),
        .inc     (w_wdt_inc),
        .expired (w_expired)
    );

    // Reset forces every strobe low in the reset cycle itself, so an
    // interrupted transfer never leaks a request or a partial write.
    assign bus.mem_req      = w_mem_req      & ~rst;
    assign bus.mem_we       = w_mem_we       & ~rst;
    assign bus.mem_addr_sel = w_mem_addr_sel & ~rst;
    assign bus.ir_we        = w_ir_we        & ~rst;
    assign bus.rf_we        = w_rf_we        & ~rst;
    assign bus.pc_we        = w_pc_we        & ~rst;
    assign bus.pc_sel       = w_pc_sel       & ~rst;
    assign bus.alu_src_b    = w_alu_src_b    & ~rst;
    assign bus.wb_sel       = rst ? 2'b00 : w_wb_sel;
    assign bus.halted       = w_halted       & ~rst;
    assign bus.error        = w_error        & ~rst;
    assign bus.instret      = rst ? 32'd0 : r_instret;
    assign bus.state        = r_state;

endmodule

`default_nettype wire
